fetch_stage: RTL and testbench

//  PC register, next-PC selection and IF/ID pipeline register.

---
 rtl/fetch_stage.sv | 47 ++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register with saturating stall/flush counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PC_en,
  input  logic             IF_ID_en,
  input  logic             Branch_Taken,
  input  logic [31:0]      Branch_Target,
  input  logic             Jump,
  input  logic [31:0]      Jump_Target,
  input  logic [31:0]      Imem_Data,
  output logic [31:0]      Imem_Addr,
  output logic [31:0]      PC_out,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic             Flush,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);
  logic [31:0] pc_plus4;
  assign pc_plus4 = PC_out + 32'd4;
  assign Flush = PC_en & (Jump | Branch_Taken);
  assign Imem_Addr = PC_out;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC_out        <= RESET_PC;
      IF_ID_Instr   <= '0;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
      Stall_Count   <= '0;
      Flush_Count   <= '0;
    end else begin
      if (PC_en) PC_out <= Jump ? Jump_Target : Branch_Taken ? Branch_Target : pc_plus4;
      if (IF_ID_en) begin
        IF_ID_Instr   <= Flush ? '0 : Imem_Data;
        IF_ID_PCPlus4 <= Flush ? '0 : pc_plus4;
        IF_ID_Valid   <= ~Flush;
      end
      if (!PC_en && Stall_Count != '1) Stall_Count <= Stall_Count + CNT_W'(1);
      if (Flush && Flush_Count != '1) Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, pc_en, if_id_en, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_data, pc_out, if_id_instr, if_id_pcplus4;
  logic if_id_valid, flush;
  logic [15:0] stall_count, flush_count;
  logic [31:0] imem_addr2, imem_data2, pc_out2, if_id_instr2, if_id_pcplus42;
  logic if_id_valid2, flush2;
  logic [1:0] stall_count2, flush_count2;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_instr, m_p4;
  logic m_valid;
  int m_stall, m_flush;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]};
  endfunction

  assign imem_data  = imem(imem_addr);
  assign imem_data2 = imem(imem_addr2);

  fetch_stage dut (
    .Clk(clk), .Rst(rst), .PC_en(pc_en), .IF_ID_en(if_id_en),
    .Branch_Taken(branch_taken), .Branch_Target(branch_target),
    .Jump(jump), .Jump_Target(jump_target), .Imem_Data(imem_data),
    .Imem_Addr(imem_addr), .PC_out(pc_out), .IF_ID_Instr(if_id_instr),
    .IF_ID_PCPlus4(if_id_pcplus4), .IF_ID_Valid(if_id_valid), .Flush(flush),
    .Stall_Count(stall_count), .Flush_Count(flush_count)
  );

  fetch_stage #(.CNT_W(2)) dut2 (
    .Clk(clk), .Rst(rst), .PC_en(pc_en), .IF_ID_en(if_id_en),
    .Branch_Taken(branch_taken), .Branch_Target(branch_target),
    .Jump(jump), .Jump_Target(jump_target), .Imem_Data(imem_data2),
    .Imem_Addr(imem_addr2), .PC_out(pc_out2), .IF_ID_Instr(if_id_instr2),
    .IF_ID_PCPlus4(if_id_pcplus42), .IF_ID_Valid(if_id_valid2), .Flush(flush2),
    .Stall_Count(stall_count2), .Flush_Count(flush_count2)
  );

  function automatic int sat(input int v, input int lim);
    return v > lim ? lim : v;
  endfunction

  task automatic tick();
    logic redirect;
    redirect = pc_en & (jump | branch_taken);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!pc_en) m_stall++;
      if (redirect) m_flush++;
      if (if_id_en) begin
        m_instr = redirect ? 0 : imem(m_pc);
        m_p4    = redirect ? 0 : m_pc + 4;
        m_valid = !redirect;
      end
      if (pc_en) m_pc = jump ? jump_target : branch_taken ? branch_target : m_pc + 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pc_en = 1; if_id_en = 1; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    tick(); tick();
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0 || if_id_pcplus4 !== 32'h0) begin errors++; $display("FAIL reset_ifid got=%h/%h exp=0/0", if_id_instr, if_id_pcplus4); end
    checks++; if (stall_count !== 0 || flush_count !== 0 || stall_count2 !== 0 || flush_count2 !== 0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d/%0d/%0d exp=0", stall_count, flush_count, stall_count2, flush_count2); end
  endtask

  task automatic test_sequential();
    rst = 0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0 got=%h exp=0", imem_addr); end
    tick();
    checks++; if (pc_out !== 32'h4 || if_id_instr !== imem(0) || if_id_pcplus4 !== 32'h4 || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_first got=%h/%h/%h/%b exp=4/%h/4/1", pc_out, if_id_instr, if_id_pcplus4, if_id_valid, imem(0)); end
    tick();
    checks++; if (pc_out !== 32'h8 || if_id_instr !== imem(4) || if_id_pcplus4 !== 32'h8 || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_second got=%h/%h/%h/%b exp=8/%h/8/1", pc_out, if_id_instr, if_id_pcplus4, if_id_valid, imem(4)); end
  endtask

  task automatic test_stall();
    pc_en = 0; if_id_en = 0;
    tick(); tick();
    checks++; if (pc_out !== 32'h8 || if_id_instr !== imem(4) || if_id_pcplus4 !== 32'h8) begin errors++; $display("FAIL stall_hold got=%h/%h/%h exp=8/%h/8", pc_out, if_id_instr, if_id_pcplus4, imem(4)); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", stall_count); end
    pc_en = 1; if_id_en = 1;
    tick();
    checks++; if (pc_out !== 32'hC || if_id_instr !== imem(8) || if_id_pcplus4 !== 32'hC) begin errors++; $display("FAIL stall_release got=%h/%h/%h exp=c/%h/c", pc_out, if_id_instr, if_id_pcplus4, imem(8)); end
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_target = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL branch_flush got=%b exp=1", flush); end
    tick();
    checks++; if (pc_out !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL branch_bubble got=%h/%b/%h exp=40/0/0", pc_out, if_id_valid, if_id_instr); end
    branch_taken = 0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL branch_noflush got=%b exp=0", flush); end
    tick();
    checks++; if (if_id_instr !== imem(32'h40) || if_id_valid !== 1'b1 || flush_count !== 16'd1) begin errors++; $display("FAIL branch_target got=%h/%b/%0d exp=%h/1/1", if_id_instr, if_id_valid, flush_count, imem(32'h40)); end
  endtask

  task automatic test_stalled_branch();
    pc_en = 0; if_id_en = 0; branch_taken = 1; branch_target = 32'h80;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stbr_flush got=%b exp=0", flush); end
    tick();
    checks++; if (pc_out !== 32'h44 || flush_count !== 16'd1) begin errors++; $display("FAIL stbr_hold got=%h/%0d exp=44/1", pc_out, flush_count); end
    pc_en = 1; if_id_en = 1; jump = 1; jump_target = 32'h100; branch_target = 32'h200;
    tick();
    checks++; if (pc_out !== 32'h100 || flush_count !== 16'd2 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_prio got=%h/%0d/%b exp=100/2/0", pc_out, flush_count, if_id_valid); end
  endtask

  task automatic test_edges();
    jump = 1; branch_taken = 0; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 0;
    tick();
    checks++; if (pc_out !== 32'h0 || if_id_pcplus4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== imem(32'hFFFF_FFFC)) begin errors++; $display("FAIL pc_wrap got=%h/%h/%b/%h exp=0/0/1/%h", pc_out, if_id_pcplus4, if_id_valid, if_id_instr, imem(32'hFFFF_FFFC)); end
    pc_en = 0; if_id_en = 0;
    repeat (5) tick();
    checks++; if (stall_count2 !== 2'd3) begin errors++; $display("FAIL sat_small got=%0d exp=3", stall_count2); end
    checks++; if (stall_count !== 16'(m_stall) || m_stall != 8) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", stall_count, m_stall); end
    branch_taken = 1; rst = 1;
    tick();
    checks++; if (pc_out !== 0 || if_id_valid !== 0 || if_id_instr !== 0 || stall_count !== 0 || flush_count !== 0 || stall_count2 !== 0) begin errors++; $display("FAIL midstall_reset got=%h/%b/%h/%0d/%0d/%0d exp=0", pc_out, if_id_valid, if_id_instr, stall_count, flush_count, stall_count2); end
    rst = 0; pc_en = 1; if_id_en = 1; branch_taken = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      pc_en = ($urandom_range(0, 3) != 0);
      if_id_en = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      jump = ($urandom_range(0, 6) == 0);
      branch_target = $urandom;
      jump_target = $urandom;
      #1;
      checks++; if (flush !== (pc_en & (jump | branch_taken))) begin errors++; $display("FAIL rnd_flush i=%0d got=%b", i, flush); end
      tick();
      checks++; if (pc_out !== m_pc || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc i=%0d got=%h/%h exp=%h", i, pc_out, imem_addr, m_pc); end
      checks++; if (if_id_instr !== m_instr || if_id_pcplus4 !== m_p4 || if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_ifid i=%0d got=%h/%h/%b exp=%h/%h/%b", i, if_id_instr, if_id_pcplus4, if_id_valid, m_instr, m_p4, m_valid); end
      checks++; if (stall_count !== 16'(sat(m_stall, 65535)) || flush_count !== 16'(sat(m_flush, 65535))) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, stall_count, flush_count, m_stall, m_flush); end
      checks++; if (stall_count2 !== 2'(sat(m_stall, 3)) || flush_count2 !== 2'(sat(m_flush, 3))) begin errors++; $display("FAIL rnd_cnt2 i=%0d got=%0d/%0d exp=%0d/%0d", i, stall_count2, flush_count2, sat(m_stall, 3), sat(m_flush, 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_stalled_branch();
    test_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
